// File: rtl/seg_scan_pkg.sv
// Shared display types and constants for the 4-digit scan path.
// Latency: none (declarations only).
// Backpressure: none.
package seg_scan_pkg;

    localparam int         SEG_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  point;
        logic [3:0]  blank;
    } disp_t;

    localparam disp_t PEND_RST   = '{data: 16'h0000, point: 4'h0, blank: 4'h0};
    localparam disp_t SHADOW_RST = '{data: 16'h0000, point: 4'h0, blank: 4'hF};

    // Active-low one-hot digit enable for a slot index.
    function automatic logic [3:0] an_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter (cnt 0..DIV-1) and digit index generator with frame-boundary and guard flags.
// Latency: flags are combinational from the registered counters.
// Backpressure: none; i_en low holds both counters at 0 and makes every cycle a boundary.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIV   = 25000,
    parameter int GUARD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [1:0] o_idx,
    output logic       o_boundary,
    output logic       o_guard
);

    localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_GUARD = CW'(GUARD);
    localparam logic [1:0]     IDX_LAST  = 2'(SEG_DIGITS - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // With scanning stopped every cycle counts as a boundary so loads commit at once.
    assign o_boundary = !i_en || (w_wrap && (r_idx == IDX_LAST));
    assign o_guard    = (r_cnt < CNT_GUARD);
    assign o_idx      = r_idx;

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-seg scan driver with frame-aligned double-buffered value update.
// Latency: outputs registered one cycle after the cnt/idx/shadow state; FRAME the cycle after commit.
// Backpressure: none; LOAD accepted every cycle, a later LOAD before commit overwrites pending.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIV   = 25000,
    parameter int GUARD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic [15:0] DATA,
    input  logic [3:0]  POINT_IN,
    input  logic [3:0]  BLANK_IN,
    input  logic        LOAD,
    output logic [3:0]  AN,
    output logic [3:0]  NIBBLE,
    output logic        LE,
    output logic        POINT,
    output logic        FRAME
);

    logic [1:0] w_idx;
    logic       w_boundary;
    logic       w_guard;
    logic       w_commit;
    disp_t      w_load_val;
    disp_t      w_commit_val;

    disp_t      r_pending;
    disp_t      r_shadow;
    logic       r_pend;
    logic       r_frame;
    logic [3:0] r_an;
    logic [3:0] r_nibble;
    logic       r_le;
    logic       r_point;

    seg_scan_timer #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (EN),
        .o_idx      (w_idx),
        .o_boundary (w_boundary),
        .o_guard    (w_guard)
    );

    assign w_load_val   = '{data: DATA, point: POINT_IN, blank: BLANK_IN};
    // A LOAD landing on the boundary cycle bypasses pending and commits directly.
    assign w_commit     = w_boundary && (r_pend || LOAD);
    assign w_commit_val = LOAD ? w_load_val : r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= PEND_RST;
            r_pend    <= 1'b0;
            r_shadow  <= SHADOW_RST;
            r_frame   <= 1'b0;
        end else begin
            if (LOAD) begin
                r_pending <= w_load_val;
            end
            r_pend <= (r_pend || LOAD) && !w_commit;
            if (w_commit) begin
                r_shadow <= w_commit_val;
            end
            r_frame <= w_commit;
        end
    end

    // Enables and decoder inputs update on the same edge; guard keeps digits dark while data settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an     <= AN_OFF;
            r_nibble <= 4'h0;
            r_le     <= 1'b1;
            r_point  <= 1'b0;
        end else begin
            r_an     <= (!EN || w_guard) ? AN_OFF : an_for(w_idx);
            r_nibble <= r_shadow.data[{w_idx, 2'b00} +: 4];
            r_le     <= r_shadow.blank[w_idx];
            r_point  <= r_shadow.point[w_idx];
        end
    end

    assign AN     = r_an;
    assign NIBBLE = r_nibble;
    assign LE     = r_le;
    assign POINT  = r_point;
    assign FRAME  = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: per-slot scoreboard of expected digit content.
// Small DIV/GUARD so full frames are short.
module tb_seg_scan_driver;
    import seg_scan_pkg::*;

    localparam int DIV       = 8;
    localparam int GUARD     = 2;
    localparam int FRAME_CYC = 4 * DIV;
    localparam int BUDGET    = 8 * FRAME_CYC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EN;
    logic [15:0] DATA;
    logic [3:0]  POINT_IN;
    logic [3:0]  BLANK_IN;
    logic        LOAD;
    logic [3:0]  AN;
    logic [3:0]  NIBBLE;
    logic        LE;
    logic        POINT;
    logic        FRAME;

    seg_scan_driver #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EN       (EN),
        .DATA     (DATA),
        .POINT_IN (POINT_IN),
        .BLANK_IN (BLANK_IN),
        .LOAD     (LOAD),
        .AN       (AN),
        .NIBBLE   (NIBBLE),
        .LE       (LE),
        .POINT    (POINT),
        .FRAME    (FRAME)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] nib;
        logic       le;
        logic       pt;
    } slot_t;

    slot_t      exp_q[$];
    slot_t      mon_e;
    int         checks     = 0;
    int         errors     = 0;
    int         frame_cnt  = 0;
    int         bad_nib    = -1;
    int         bad_seen   = 0;
    int         le_lo_seen = 0;
    int         run        = 0;
    bit         mon_on     = 1'b0;
    bit         chk_len    = 1'b0;
    logic [3:0] prev_an    = 4'b1111;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                              input int first, input int last);
        for (int i = first; i <= last; i++) begin
            slot_t s;
            s.an  = 4'b1111 ^ (4'b0001 << i);
            s.nib = d[4*i +: 4];
            s.le  = b[i];
            s.pt  = p[i];
            exp_q.push_back(s);
        end
    endtask

    // Caller is at posedge+1; LOAD is high for exactly one cycle.
    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        DATA     = d;
        POINT_IN = p;
        BLANK_IN = b;
        LOAD     = 1'b1;
        @(posedge clk);
        #1;
        LOAD     = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!FRAME && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, FRAME, 1);
    endtask

    task automatic wait_qsize(input int sz, input string tag);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (exp_q.size() > sz && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, exp_q.size(), sz);
    endtask

    // Returns at the negedge where a lit run with the given AN begins.
    task automatic wait_an_start(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (AN != 4'b1111 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        while (AN != target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk(tag, AN, target);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("an_onehot", int'($countones(~AN) <= 1), 1);
            if (FRAME) frame_cnt++;
            if (AN != 4'b1111) begin
                if (int'(NIBBLE) == bad_nib) bad_seen++;
                if (!LE) le_lo_seen++;
            end
            if (AN != 4'b1111 && prev_an == 4'b1111) begin
                if (chk_len) chk("guard_len", run, GUARD);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("slot_an", AN, mon_e.an);
                    chk("slot_nib", NIBBLE, mon_e.nib);
                    chk("slot_le", LE, mon_e.le);
                    chk("slot_pt", POINT, mon_e.pt);
                end
                run = 1;
            end else if (AN == 4'b1111 && prev_an != 4'b1111) begin
                if (chk_len) chk("lit_len", run, DIV - GUARD);
                run = 1;
            end else begin
                run++;
            end
            prev_an = AN;
        end
    end

    initial begin
        int f0;
        int n;
        rst_n    = 1'b0;
        EN       = 1'b0;
        LOAD     = 1'b0;
        DATA     = 16'h0000;
        POINT_IN = 4'h0;
        BLANK_IN = 4'h0;

        // Reset values, then idle with scan disabled and then enabled but nothing loaded.
        repeat (2) @(negedge clk);
        chk("rst_an", AN, 4'hF);
        chk("rst_nib", NIBBLE, 0);
        chk("rst_le", LE, 1);
        chk("rst_pt", POINT, 0);
        chk("rst_frame", FRAME, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_an", AN, 4'hF);
            chk("idle_le", LE, 1);
            chk("idle_frame", FRAME, 0);
        end
        @(posedge clk);
        #1;
        EN = 1'b1;
        repeat (FRAME_CYC + 4) begin
            @(negedge clk);
            chk("blank_le", LE, 1);
            chk("blank_frame", FRAME, 0);
        end

        // Scan order.
        f0 = frame_cnt;
        @(posedge clk);
        #1;
        do_load(16'h1234, 4'b0100, 4'b0000);
        wait_frame("scan_commit");
        push_frame(16'h1234, 4'b0100, 4'b0000, 0, 3);
        push_frame(16'h1234, 4'b0100, 4'b0000, 0, 3);
        chk_len = 1'b1;
        wait_qsize(6, "scan_wait");
        chk("scan_frames", frame_cnt - f0, 1);

        // Tear-free: load while slot 1 of the second 1234 frame is lit.
        wait_qsize(2, "tear_wait");
        f0 = frame_cnt;
        do_load(16'hABCD, 4'b0001, 4'b0000);
        push_frame(16'hABCD, 4'b0001, 4'b0000, 0, 3);
        wait_qsize(0, "tear_drain");
        chk("tear_frames", frame_cnt - f0, 1);

        // Boundary collision: 5555 pending, 6666 on the boundary cycle itself.
        push_frame(16'hABCD, 4'b0001, 4'b0000, 0, 3);
        wait_qsize(1, "coll_wait");
        f0       = frame_cnt;
        bad_nib  = 5;
        bad_seen = 0;
        do_load(16'h5555, 4'b0000, 4'b0000);
        wait_an_start(4'b0111, "coll_slot3");
        repeat (4) @(posedge clk);
        #1;
        do_load(16'h6666, 4'b1000, 4'b0000);
        push_frame(16'h6666, 4'b1000, 4'b0000, 0, 3);
        wait_qsize(0, "coll_drain");
        repeat (DIV) @(posedge clk);
        #1;
        chk("coll_frames", frame_cnt - f0, 1);
        chk("coll_no5555", bad_seen, 0);

        // Blanking, then EN low mid slot 2 with an immediate commit while stopped.
        do_load(16'h4321, 4'b0000, 4'b1000);
        wait_frame("blank_commit");
        push_frame(16'h4321, 4'b0000, 4'b1000, 0, 3);
        push_frame(16'h4321, 4'b0000, 4'b1000, 0, 2);
        wait_qsize(0, "en_wait");
        chk_len = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        EN = 1'b0;
        @(negedge clk);
        chk("en_fall_prev", AN, 4'b1011);
        @(negedge clk);
        chk("en_low_an", AN, 4'hF);
        @(posedge clk);
        #1;
        do_load(16'h0F0F, 4'b0001, 4'b0000);
        @(negedge clk);
        chk("en_low_frame", FRAME, 1);
        @(negedge clk);
        chk("en_low_frame_end", FRAME, 0);
        chk("en_low_dark", AN, 4'hF);
        push_frame(16'h0F0F, 4'b0001, 4'b0000, 0, 3);
        @(posedge clk);
        #1;
        EN = 1'b1;
        n  = 0;
        @(negedge clk);
        while (AN == 4'hF && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
        chk("restart_guard", n, GUARD + 1);
        chk("restart_an", AN, 4'b1110);
        wait_qsize(3, "restart_wait");
        chk_len = 1'b1;
        wait_qsize(0, "restart_drain");

        // Asynchronous reset between edges with a load pending.
        wait_an_start(4'b1101, "arst_slot1");
        @(posedge clk);
        #1;
        do_load(16'h7777, 4'hF, 4'h0);
        chk_len = 1'b0;
        bad_nib = 7;
        f0      = frame_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an", AN, 4'hF);
        chk("arst_nib", NIBBLE, 0);
        chk("arst_le", LE, 1);
        chk("arst_pt", POINT, 0);
        chk("arst_frame", FRAME, 0);
        bad_seen   = 0;
        le_lo_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5 * FRAME_CYC) @(posedge clk);
        #1;
        chk("arst_frames", frame_cnt - f0, 0);
        chk("arst_no7777", bad_seen, 0);
        chk("arst_le_dark", le_lo_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
